wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter.sv | 128 ++++++++++++
 tb/tb_wb_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Write-back arbiter: link > mem > alu requests funnel into a 4-entry FIFO that drains one
// register-file write per cycle. Define WB_PENDING_EN to add the qReg/qPending hazard query.
module wb_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        linkValid,
    input  logic [31:0] linkData,
    output logic        linkReady,
    input  logic        memValid,
    input  logic [4:0]  memReg,
    input  logic [31:0] memData,
    output logic        memReady,
    input  logic        aluValid,
    input  logic [4:0]  aluReg,
    input  logic [31:0] aluData,
    output logic        aluReady,
    output logic        regWrite,
    output logic [4:0]  writeReg,
    output logic [31:0] writeData
`ifdef WB_PENDING_EN
    ,
    input  logic [4:0]  qReg,
    output logic        qPending
`endif
);

    localparam logic [4:0] LinkReg = 5'd31;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } entry_t;

    entry_t     fifoMem [4];
    logic [2:0] countQ, countD;
    logic [1:0] rdPtrQ, rdPtrD;
    logic [1:0] wrPtrQ, wrPtrD;

    logic   pop;
    logic   space;
    logic   accept;
    logic   push;
    entry_t pushEntry;

    // The head drains on every edge it exists, so a full FIFO always frees a slot.
    assign pop   = !rst && (countQ != 3'd0);
    assign space = (countQ < 3'd4) || pop;

    always_comb begin
        linkReady = 1'b0;
        memReady  = 1'b0;
        aluReady  = 1'b0;
        if (!rst && space) begin
            if (linkValid) begin
                linkReady = 1'b1;
            end else if (memValid) begin
                memReady = 1'b1;
            end else if (aluValid) begin
                aluReady = 1'b1;
            end
        end
    end

    always_comb begin
        pushEntry = '{rd: aluReg, data: aluData};
        if (linkReady) begin
            pushEntry = '{rd: LinkReg, data: linkData};
        end else if (memReady) begin
            pushEntry = '{rd: memReg, data: memData};
        end
    end

    // Writes to r0 complete the handshake but are never queued.
    assign accept = linkReady || memReady || aluReady;
    assign push   = accept && (pushEntry.rd != 5'd0);

    always_comb begin
        countD = countQ + {2'b00, push} - {2'b00, pop};
        wrPtrD = wrPtrQ + {1'b0, push};
        rdPtrD = rdPtrQ + {1'b0, pop};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            countQ    <= 3'd0;
            rdPtrQ    <= 2'd0;
            wrPtrQ    <= 2'd0;
            regWrite  <= 1'b0;
            writeReg  <= 5'd0;
            writeData <= 32'd0;
        end else begin
            countQ   <= countD;
            rdPtrQ   <= rdPtrD;
            wrPtrQ   <= wrPtrD;
            regWrite <= pop;
            if (pop) begin
                writeReg  <= fifoMem[rdPtrQ].rd;
                writeData <= fifoMem[rdPtrQ].data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifoMem[wrPtrQ] <= pushEntry;
        end
    end

`ifdef WB_PENDING_EN
    logic       fifoHit;
    logic [1:0] slot;

    // Scan only the occupied slots, starting from the head.
    always_comb begin
        fifoHit = 1'b0;
        slot    = 2'd0;
        for (int i = 0; i < 4; i++) begin
            slot = rdPtrQ + 2'(i);
            if ((3'(i) < countQ) && (fifoMem[slot].rd == qReg)) begin
                fifoHit = 1'b1;
            end
        end
    end

    assign qPending = (qReg != 5'd0) && (fifoHit || (regWrite && (writeReg == qReg)));
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed vector table, reset/r0 sequences and a
// scoreboard-checked random burst.
module tb_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        linkValid, memValid, aluValid;
    logic [31:0] linkData, memData, aluData;
    logic [4:0]  memReg, aluReg;
    logic        linkReady, memReady, aluReady;
    logic        regWrite;
    logic [4:0]  writeReg;
    logic [31:0] writeData;
`ifdef WB_PENDING_EN
    logic [4:0]  qReg = 5'd0;
    logic        qPending;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    wb_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .linkValid (linkValid),
        .linkData  (linkData),
        .linkReady (linkReady),
        .memValid  (memValid),
        .memReg    (memReg),
        .memData   (memData),
        .memReady  (memReady),
        .aluValid  (aluValid),
        .aluReg    (aluReg),
        .aluData   (aluData),
        .aluReady  (aluReady),
        .regWrite  (regWrite),
        .writeReg  (writeReg),
        .writeData (writeData)
`ifdef WB_PENDING_EN
        ,
        .qReg      (qReg),
        .qPending  (qPending)
`endif
    );

    typedef struct {
        logic        lv;
        logic [31:0] ld;
        logic        mv;
        logic [4:0]  mr;
        logic [31:0] md;
        logic        av;
        logic [4:0]  ar;
        logic [31:0] ad;
        logic [2:0]  expRdy;
        logic        expRw;
        logic [4:0]  expWr;
        logic [31:0] expWd;
    } vec_t;

    vec_t vecs [14];

    function automatic vec_t mk(input logic lv, input logic [31:0] ld, input logic mv,
                                input logic [4:0] mr, input logic [31:0] md, input logic av,
                                input logic [4:0] ar, input logic [31:0] ad,
                                input logic [2:0] rdy, input logic rw, input logic [4:0] wr,
                                input logic [31:0] wd);
        vec_t v;
        v.lv = lv; v.ld = ld; v.mv = mv; v.mr = mr; v.md = md;
        v.av = av; v.ar = ar; v.ad = ad;
        v.expRdy = rdy; v.expRw = rw; v.expWr = wr; v.expWd = wd;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic lv, input logic [31:0] ld, input logic mv,
                         input logic [4:0] mr, input logic [31:0] md, input logic av,
                         input logic [4:0] ar, input logic [31:0] ad);
        linkValid = lv; linkData = ld;
        memValid = mv; memReg = mr; memData = md;
        aluValid = av; aluReg = ar; aluData = ad;
    endtask

    task automatic idle();
        drive(1'b0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] rdyVec();
        return {linkReady, memReady, aluReady};
    endfunction

    function automatic logic [37:0] outVec();
        return {regWrite, writeReg, writeData};
    endfunction

    // Random-phase state
    logic [36:0] sb[$];
    logic        pL, pM, pA;
    logic [31:0] dL, dM, dA;
    logic [4:0]  rM, rA;
    int          gen;
    logic        popped;
    logic [36:0] expHead;
    logic [2:0]  expRdy;
    logic        space;
    int          cyc;

    initial begin
        // Reset with every source requesting: no ready may rise.
        rst = 1'b1;
        drive(1'b1, 32'h1, 1'b1, 5'd2, 32'h2, 1'b1, 5'd3, 32'h3);
        #3;
        check("reset_ready", 64'(rdyVec()), 64'd0);
        tick();
        tick();
        check("reset_out", 64'(outVec()), 64'd0);
        rst = 1'b0;
        idle();

        vecs[0]  = mk(0, 0, 0, 0, 0, 1, 5, 32'hDEADBEEF, 3'b001, 0, 5'd0, 32'd0);
        vecs[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 1, 5'd5, 32'hDEADBEEF);
        vecs[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 5'd5, 32'hDEADBEEF);
        vecs[3]  = mk(1, 32'h400008, 1, 8, 32'h11, 1, 9, 32'h22, 3'b100, 0, 5'd5, 32'hDEADBEEF);
        vecs[4]  = mk(0, 0, 1, 8, 32'h11, 1, 9, 32'h22, 3'b010, 1, 5'd31, 32'h400008);
        vecs[5]  = mk(0, 0, 0, 0, 0, 1, 9, 32'h22, 3'b001, 1, 5'd8, 32'h11);
        vecs[6]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 1, 5'd9, 32'h22);
        vecs[7]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 5'd9, 32'h22);
        vecs[8]  = mk(0, 0, 0, 0, 0, 1, 0, 32'h1234, 3'b001, 0, 5'd9, 32'h22);
        vecs[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 5'd9, 32'h22);
        vecs[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 5'd9, 32'h22);
        vecs[11] = mk(0, 0, 1, 3, 32'hA5, 1, 0, 32'h7, 3'b010, 0, 5'd9, 32'h22);
        vecs[12] = mk(0, 0, 0, 0, 0, 1, 0, 32'h7, 3'b001, 1, 5'd3, 32'hA5);
        vecs[13] = mk(0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 5'd3, 32'hA5);

        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].lv, vecs[i].ld, vecs[i].mv, vecs[i].mr, vecs[i].md,
                  vecs[i].av, vecs[i].ar, vecs[i].ad);
            #3;
            check($sformatf("vec%0d_ready", i), 64'(rdyVec()), 64'(vecs[i].expRdy));
            tick();
            check($sformatf("vec%0d_out", i), 64'(outVec()),
                  64'({vecs[i].expRw, vecs[i].expWr, vecs[i].expWd}));
        end
        idle();

        // Random burst: sources hold requests until accepted; scoreboard tracks FIFO order.
        pL = 0; pM = 0; pA = 0;
        dL = 0; dM = 0; dA = 0; rM = 0; rA = 0;
        gen = 0;
        cyc = 0;
        while ((gen < 20 || pL || pM || pA || sb.size() != 0) && cyc < 400) begin
            cyc++;
            if (!pL && gen < 20 && $urandom_range(0, 2) == 0) begin
                pL = 1; dL = $urandom; gen++;
            end
            if (!pM && gen < 20 && $urandom_range(0, 1) == 0) begin
                pM = 1; rM = 5'($urandom_range(0, 31)); dM = $urandom; gen++;
            end
            if (!pA && gen < 20 && $urandom_range(0, 1) == 0) begin
                pA = 1; rA = 5'($urandom_range(0, 31)); dA = $urandom; gen++;
            end
            drive(pL, dL, pM, rM, dM, pA, rA, dA);
            #3;
            space  = (sb.size() < 4) || (sb.size() > 0);
            expRdy = 3'b000;
            if (space) begin
                if (pL) expRdy = 3'b100;
                else if (pM) expRdy = 3'b010;
                else if (pA) expRdy = 3'b001;
            end
            check("rand_ready", 64'(rdyVec()), 64'(expRdy));
            popped  = (sb.size() > 0);
            expHead = popped ? sb.pop_front() : 37'd0;
            if (expRdy[2]) begin
                sb.push_back({5'd31, dL}); pL = 0;
            end else if (expRdy[1]) begin
                if (rM != 0) sb.push_back({rM, dM});
                pM = 0;
            end else if (expRdy[0]) begin
                if (rA != 0) sb.push_back({rA, dA});
                pA = 0;
            end
            tick();
            check("rand_regWrite", 64'(regWrite), 64'(popped));
            if (popped) check("rand_write", 64'({writeReg, writeData}), 64'(expHead));
        end
        if (cyc >= 400) check("rand_timeout", 64'(cyc), 64'd0);
        idle();
        tick();
        check("rand_drained", 64'(regWrite), 64'd0);

        // Reset mid-queue: queued r7 write must never appear.
        drive(0, 0, 0, 0, 0, 1, 7, 32'h70);
        tick();
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 1, 6, 32'h60);
        #3;
        check("midrst_ready", 64'(rdyVec()), 64'd0);
        tick();
        rst = 1'b0;
        idle();
        check("midrst_out", 64'(outVec()), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("midrst_quiet%0d", i), 64'(regWrite), 64'd0);
        end

`ifdef WB_PENDING_EN
        qReg = 5'd8;
        drive(0, 0, 1, 8, 32'h88, 0, 0, 0);
        tick();
        idle();
        #1;
        check("pend_queued", 64'(qPending), 64'd1);
        tick();
        check("pend_writing", 64'(qPending), 64'd1);
        tick();
        check("pend_drained", 64'(qPending), 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
